// File: rtl/spi_rb_pkg.sv
// spi_rb_pkg: shared FSM state type and command-format constants for the SPI register bank
package spi_rb_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_e;
    localparam int CMD_W  = 8;
    localparam int RW_BIT = 7;
endpackage

// File: rtl/spi_burst_reg_bank_if.sv
// spi_burst_reg_bank_if: SPI bus signals shared by the host side and the register bank
interface spi_burst_reg_bank_if;
    logic spi_cpol;
    logic spi_cpha;
    logic spi_cs_n;
    logic spi_clk;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;
    modport master (
        output spi_cpol, spi_cpha, spi_cs_n, spi_clk, spi_mosi,
        input  spi_miso, spi_miso_oe
    );
    modport slave (
        input  spi_cpol, spi_cpha, spi_cs_n, spi_clk, spi_mosi,
        output spi_miso, spi_miso_oe
    );
endinterface

// File: rtl/spi_burst_reg_bank_sync.sv
// spi_burst_reg_bank_sync: multi-flop synchronizer, one independent chain per input bit
module spi_burst_reg_bank_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [STAGES-1:0][WIDTH-1:0] ff;
    // shift every input bit through its chain; reset clears all stages to 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ff <= '0;
        else     ff <= {ff[STAGES-2:0], d};
    end
    assign q = ff[STAGES-1];
endmodule

// File: rtl/spi_burst_reg_bank.sv
// spi_burst_reg_bank: SPI slave giving burst read/write access to RW and RO register banks
module spi_burst_reg_bank
    import spi_rb_pkg::*;
#(
    parameter int NUM_REGS    = 8,
    parameter int REG_WIDTH   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    spi_burst_reg_bank_if.slave           spi,
    output logic [NUM_REGS*REG_WIDTH-1:0] rw_regs,
    input  logic [NUM_REGS*REG_WIDTH-1:0] ro_regs,
    output logic [NUM_REGS-1:0]           wr_strobe,
    output logic                          frame_err
);
    localparam int         AW        = $clog2(2 * NUM_REGS);
    localparam logic [4:0] CMD_LAST  = 5'(CMD_W - 1);
    localparam logic [4:0] WORD_LAST = 5'(REG_WIDTH - 1);
    localparam logic [4:0] RW_POS    = 5'(CMD_W - 1 - RW_BIT);

    logic                 cpol_s, cpha_s, cs_n_s, sclk_s, mosi_s;
    state_e               state, state_nxt;
    logic                 cs_prev, sclk_prev, samp_rise, is_write;
    logic [4:0]           bit_cnt;
    logic [AW-1:0]        addr, nxt_addr;
    logic [REG_WIDTH-2:0] rx;
    logic [REG_WIDTH-1:0] tx, rx_word, rd_word;
    logic [AW-2:0]        rd_idx, wr_idx;
    logic                 cs_fall, active, sample, shift, cmd_done, word_done, abort, rd_frame;

    spi_burst_reg_bank_sync #(.STAGES(SYNC_STAGES), .WIDTH(5)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({spi.spi_cpol, spi.spi_cpha, spi.spi_cs_n, spi.spi_clk, spi.spi_mosi}),
        .q   ({cpol_s, cpha_s, cs_n_s, sclk_s, mosi_s})
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // FSM next state: only a real CS fall starts a frame, any CS high ends it
    always_comb begin
        state_nxt = cs_n_s                       ? ST_IDLE :
                    (state == ST_IDLE && cs_fall) ? ST_CMD  :
                    cmd_done                     ? ST_DATA : state;
    end

    // FSM outputs: SCLK edge decode, word completion, read mux and MISO drive
    always_comb begin
        cs_fall         = cs_prev & ~cs_n_s;
        active          = (state != ST_IDLE) & ~cs_n_s;
        sample          = active & (samp_rise ? (sclk_s & ~sclk_prev) : (~sclk_s & sclk_prev));
        shift           = active & (samp_rise ? (~sclk_s & sclk_prev) : (sclk_s & ~sclk_prev));
        cmd_done        = sample && state == ST_CMD && bit_cnt == CMD_LAST;
        word_done       = sample && state == ST_DATA && bit_cnt == WORD_LAST;
        abort           = cs_n_s && state != ST_IDLE && bit_cnt != '0;
        rx_word         = {rx, mosi_s};
        nxt_addr        = cmd_done ? {rx[AW-2:0], mosi_s} : addr + AW'(1);
        rd_idx          = nxt_addr[AW-2:0];
        wr_idx          = addr[AW-2:0];
        rd_word         = nxt_addr[AW-1] ? ro_regs[int'(rd_idx) * REG_WIDTH +: REG_WIDTH]
                                         : rw_regs[int'(rd_idx) * REG_WIDTH +: REG_WIDTH];
        rd_frame        = ~is_write & (state == ST_DATA || (state == ST_CMD && bit_cnt != '0));
        spi.spi_miso    = (state == ST_DATA && !is_write) ? tx[REG_WIDTH-1] : 1'b0;
        spi.spi_miso_oe = rd_frame & ~cs_n_s;
    end

    // frame control: edge history, mode latch, bit counter, address and error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_prev   <= 1'b0;
            sclk_prev <= 1'b0;
            samp_rise <= 1'b1;
            is_write  <= 1'b0;
            bit_cnt   <= '0;
            addr      <= '0;
            frame_err <= 1'b0;
        end else begin
            cs_prev   <= cs_n_s;
            sclk_prev <= sclk_s;
            if (cs_fall) samp_rise <= ~(cpol_s ^ cpha_s);
            if (sample && state == ST_CMD && bit_cnt == RW_POS) is_write <= mosi_s;
            if (cs_n_s || state == ST_IDLE || cmd_done || word_done) bit_cnt <= '0;
            else if (sample) bit_cnt <= bit_cnt + 5'd1;
            if (cmd_done || word_done) addr <= nxt_addr;
            if (abort) frame_err <= 1'b1;
            else if (cmd_done) frame_err <= 1'b0;
        end
    end

    // shift registers: snapshot the read word at word start, hold its MSB until the first sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx <= '0;
            tx <= '0;
        end else begin
            if (sample) rx <= rx_word[REG_WIDTH-2:0];
            if (cmd_done || word_done) tx <= rd_word;
            else if (shift && state == ST_DATA && bit_cnt != '0) tx <= {tx[REG_WIDTH-2:0], 1'b0};
        end
    end

    // register file: commit a completed write word to an RW address and pulse its strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rw_regs   <= '0;
            wr_strobe <= '0;
        end else begin
            wr_strobe <= '0;
            if (word_done && is_write && !addr[AW-1]) begin
                rw_regs[int'(wr_idx) * REG_WIDTH +: REG_WIDTH] <= rx_word;
                wr_strobe[wr_idx] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spi_burst_reg_bank.sv
// tb_spi_burst_reg_bank: directed table-driven bench for the SPI burst register bank
module tb_spi_burst_reg_bank;
    localparam int NR = 8;
    localparam int RW = 8;
    localparam int HP = 8;

    typedef struct packed {
        logic        pol;
        logic        pha;
        logic [7:0]  cmd;
        logic [1:0]  nw;
        logic [23:0] wd;
        logic [23:0] rd;
        logic [63:0] rw;
        logic [7:0]  stb;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [NR*RW-1:0] rw_regs, ro_regs;
    logic [NR-1:0] wr_strobe;
    logic frame_err;
    int n_tests = 0;
    int n_fail = 0;
    logic [NR-1:0] stb_or;
    int stb_cnt;
    int oe_hi;
    vec_t vec [7];

    always #5 clk = ~clk;

    spi_burst_reg_bank_if spi();

    spi_burst_reg_bank #(.NUM_REGS(NR), .REG_WIDTH(RW), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .spi       (spi),
        .rw_regs   (rw_regs),
        .ro_regs   (ro_regs),
        .wr_strobe (wr_strobe),
        .frame_err (frame_err)
    );

    always @(negedge clk) begin
        stb_or  = stb_or | wr_strobe;
        stb_cnt = stb_cnt + $countones(wr_strobe);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_half();
        repeat (HP) @(negedge clk);
    endtask

    task automatic clr_mon();
        #1;
        stb_or  = '0;
        stb_cnt = 0;
        oe_hi   = 0;
    endtask

    task automatic start(input logic pol, input logic pha);
        spi.spi_cpol = pol;
        spi.spi_cpha = pha;
        spi.spi_clk  = pol;
        spi.spi_cs_n = 1'b1;
        repeat (6) @(negedge clk);
        spi.spi_cs_n = 1'b0;
        wait_half();
    endtask

    task automatic stop();
        wait_half();
        spi.spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] b, input int n, output logic [7:0] r);
        r = '0;
        for (int i = 0; i < n; i++) begin
            if (!spi.spi_cpha) begin
                spi.spi_mosi = b[7-i];
                wait_half();
                r = {r[6:0], spi.spi_miso};
                oe_hi += int'(spi.spi_miso_oe);
                spi.spi_clk = ~spi.spi_cpol;
                wait_half();
                spi.spi_clk = spi.spi_cpol;
            end else begin
                spi.spi_clk  = ~spi.spi_cpol;
                spi.spi_mosi = b[7-i];
                wait_half();
                r = {r[6:0], spi.spi_miso};
                oe_hi += int'(spi.spi_miso_oe);
                spi.spi_clk = spi.spi_cpol;
                wait_half();
            end
        end
    endtask

    initial begin
        logic [7:0] r;
        logic [63:0] prev;
        vec[0] = '{1'b0, 1'b0, 8'h82, 2'd2, 24'h002211, 24'h000000, 64'h0000_0000_2211_0000, 8'h0C};
        vec[1] = '{1'b1, 1'b1, 8'h0E, 2'd2, 24'h000000, 24'h005AA5, 64'h0000_0000_2211_0000, 8'h00};
        vec[2] = '{1'b0, 1'b0, 8'h8F, 2'd3, 24'h030201, 24'h000000, 64'h0000_0000_2211_0302, 8'h03};
        vec[3] = '{1'b0, 1'b1, 8'h02, 2'd2, 24'h000000, 24'h002211, 64'h0000_0000_2211_0302, 8'h00};
        vec[4] = '{1'b1, 1'b0, 8'h85, 2'd1, 24'h0000C3, 24'h000000, 64'h0000_C300_2211_0302, 8'h20};
        vec[5] = '{1'b0, 1'b0, 8'h07, 2'd3, 24'h000000, 24'h313000, 64'h0000_C300_2211_0302, 8'h00};
        vec[6] = '{1'b1, 1'b1, 8'h8A, 2'd1, 24'h000077, 24'h000000, 64'h0000_C300_2211_0302, 8'h00};
        ro_regs = 64'h5AA5_3534_3332_3130;
        spi.spi_cpol = 1'b0;
        spi.spi_cpha = 1'b0;
        spi.spi_cs_n = 1'b1;
        spi.spi_clk  = 1'b0;
        spi.spi_mosi = 1'b0;
        stb_or  = '0;
        stb_cnt = 0;
        oe_hi   = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rw_regs", rw_regs, 64'h0);
        chk("rst_strobe", 64'(wr_strobe), 64'h0);
        chk("rst_miso", 64'(spi.spi_miso), 64'h0);
        chk("rst_miso_oe", 64'(spi.spi_miso_oe), 64'h0);
        chk("rst_frame_err", 64'(frame_err), 64'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            clr_mon();
            start(vec[i].pol, vec[i].pha);
            xfer(vec[i].cmd, 8, r);
            chk($sformatf("v%0d_cmd_miso", i), 64'(r), 64'h0);
            oe_hi = 0;
            for (int w = 0; w < int'(vec[i].nw); w++) begin
                xfer(vec[i].wd[w*8 +: 8], 8, r);
                chk($sformatf("v%0d_word%0d", i, w), 64'(r), 64'(vec[i].rd[w*8 +: 8]));
            end
            chk($sformatf("v%0d_oe_bits", i), 64'(oe_hi), vec[i].cmd[7] ? 64'h0 : 64'(8 * int'(vec[i].nw)));
            stop();
            chk($sformatf("v%0d_rw_regs", i), rw_regs, vec[i].rw);
            chk($sformatf("v%0d_strobe_bits", i), 64'(stb_or), 64'(vec[i].stb));
            chk($sformatf("v%0d_strobe_pulses", i), 64'(stb_cnt), 64'($countones(vec[i].stb)));
            chk($sformatf("v%0d_frame_err", i), 64'(frame_err), 64'h0);
        end

        prev = rw_regs;
        clr_mon();
        start(1'b0, 1'b0);
        xfer(8'h81, 8, r);
        xfer(8'hFF, 5, r);
        stop();
        chk("abort_word_rw", rw_regs, prev);
        chk("abort_word_strobe", 64'(stb_cnt), 64'h0);
        chk("abort_word_err", 64'(frame_err), 64'h1);
        start(1'b0, 1'b0);
        xfer(8'h00, 8, r);
        chk("err_clear_after_cmd", 64'(frame_err), 64'h0);
        stop();
        chk("boundary_rise_no_err", 64'(frame_err), 64'h0);
        start(1'b0, 1'b0);
        xfer(8'h83, 3, r);
        stop();
        chk("abort_cmd_err", 64'(frame_err), 64'h1);
        chk("abort_cmd_rw", rw_regs, prev);

        start(1'b0, 1'b0);
        xfer(8'h84, 8, r);
        xfer(8'hAB, 4, r);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_rw_regs", rw_regs, 64'h0);
        chk("midrst_frame_err", 64'(frame_err), 64'h0);
        chk("midrst_miso_oe", 64'(spi.spi_miso_oe), 64'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        clr_mon();
        xfer(8'hCD, 4, r);
        xfer(8'hEF, 8, r);
        chk("midrst_no_write", rw_regs, 64'h0);
        chk("midrst_no_strobe", 64'(stb_cnt), 64'h0);
        chk("midrst_oe_idle", 64'(spi.spi_miso_oe), 64'h0);
        chk("midrst_miso_idle", 64'(spi.spi_miso), 64'h0);
        stop();
        chk("midrst_rise_no_err", 64'(frame_err), 64'h0);
        clr_mon();
        start(1'b0, 1'b0);
        xfer(8'h84, 8, r);
        xfer(8'h99, 8, r);
        stop();
        chk("post_rst_write", rw_regs, 64'h0000_0099_0000_0000);
        chk("post_rst_strobe", 64'(stb_or), 64'h10);
        chk("post_rst_pulses", 64'(stb_cnt), 64'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_burst_reg_bank.md
SPI_BURST_REG_BANK -- requirements
Module: spi_burst_reg_bank

Interface
REQ-001 Parameter NUM_REGS, default 8: number of RW registers and of RO registers; power of two, 2..64.
REQ-002 Parameter REG_WIDTH, default 8: register and data-word width in bits, 8..32.
REQ-003 Parameter SYNC_STAGES, default 2: flops per input synchronizer, at least 2.
REQ-004 Port clk, input, 1: system clock; one clock, and every flop is clocked on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port spi_cpol, input, 1: SPI clock polarity.
REQ-007 Port spi_cpha, input, 1: SPI clock phase.
REQ-008 Port spi_cs_n, input, 1: chip select, active-low.
REQ-009 Port spi_clk, input, 1: SPI serial clock.
REQ-010 Port spi_mosi, input, 1: serial data in.
REQ-011 Port spi_miso, output, 1: serial data out.
REQ-012 Port spi_miso_oe, output, 1: MISO drive enable (1 = drive, 0 = HiZ).
REQ-013 Port rw_regs, output, NUM_REGS*REG_WIDTH: RW register contents; register k occupies bits [k*REG_WIDTH +: REG_WIDTH].
REQ-014 Port ro_regs, input, NUM_REGS*REG_WIDTH: status values, read-only from SPI.
REQ-015 Port wr_strobe, output, NUM_REGS: one-clk pulse on bit k when RW register k is written.
REQ-016 Port frame_err, output, 1: sticky flag set by an aborted word; cleared by rst or by the next command phase completing.

Function
REQ-017 All five SPI inputs SHALL pass through SYNC_STAGES synchronizers; all decoding uses the synchronized values.
REQ-018 Sample edge SHALL be the rising edge of the synced SCLK when cpol^cpha = 0, and the falling edge otherwise; the shift edge is the opposite edge.
REQ-019 Address width AW = log2(2*NUM_REGS); addresses 0..NUM_REGS-1 select RW registers; addresses NUM_REGS..2*NUM_REGS-1 select RO registers.
REQ-020 Frame: CS fall, then an 8-bit command MSB-first (bit7: 1 = write, 0 = read; bits[AW-1:0] = start address; bits[6:AW] ignored), then any number of REG_WIDTH-bit data words, MSB-first.
REQ-021 FSM states: IDLE -> CMD on CS fall; CMD -> DATA after the 8th sample edge; DATA -> DATA per word; any state -> IDLE on CS rise.
REQ-022 Address SHALL auto-increment after each completed data word and wrap from 2*NUM_REGS-1 to 0.
REQ-023 Write: on the sample edge of a word's last bit, the register is updated on the next clk and the matching wr_strobe bit pulses for exactly one clk.
REQ-024 A write to an RO address is ignored: no register change and no strobe.
REQ-025 Read: the addressed register (RW or RO) is snapshotted at word start; the snapshot is shifted out MSB-first, and a concurrent change to the register does not alter the word in flight.
REQ-026 For cpha = 0, the first data bit is valid on spi_miso within 1 clk of entering DATA; for cpha = 1, it is valid after the first shift edge.
REQ-027 During the command phase and write frames, spi_miso SHALL be 0.
REQ-028 spi_miso_oe SHALL equal the inverse of the synced CS in read frames, and 0 otherwise.
REQ-029 A CS rise mid-command or mid-word SHALL discard the partial word, write nothing, and set frame_err; a CS rise on a word boundary does not set frame_err.
REQ-030 SCLK edges while CS is high SHALL be ignored.
REQ-031 cpol/cpha are sampled at CS fall and held constant for the whole frame.

Reset
REQ-032 While rst is high: FSM = IDLE, rw_regs = 0, wr_strobe = 0, spi_miso = 0, spi_miso_oe = 0, frame_err = 0, synchronizers = 0.
REQ-033 The CS synchronizer resets to 0; the FSM SHALL only leave IDLE on a genuine high-to-low edge of the synced CS after reset, so a frame already in progress is ignored until the next CS rise.

Structure
REQ-034 Package spi_rb_pkg holds the FSM state enum, the command width constant (8), and the R/W bit index (7).
REQ-035 The block instantiates the existing synchronizer sub-module; all other logic is flat within the module.

Verification
REQ-036 Mode 0, write cmd 0x82 then data 0x11, 0x22 -> reg2 = 0x11, reg3 = 0x22, wr_strobe[2] then wr_strobe[3] each pulse once.
REQ-037 Mode 3, read cmd 0x0E (RO index 6), ro_regs word 6 = 0xA5 and word 7 = 0x5A, two words clocked -> MISO returns 0xA5, 0x5A, and spi_miso_oe = 1 throughout the frame.
REQ-038 Write cmd 0x8F then three words 0x01, 0x02, 0x03 -> address 15 (RO) is ignored, address wraps to 0 and 1, giving reg0 = 0x02 and reg1 = 0x03.
REQ-039 Write cmd 0x81, then CS rise after 5 data bits -> reg1 is unchanged, no strobe, frame_err = 1; the next valid command clears it.
REQ-040 rst asserted mid-write, then released with CS still low -> all outputs are 0, and no write occurs until a new CS fall.
